// File: rtl/adiabatic_clock_sequencer.sv
// -----------------------------------------------------------------------------
// adiabatic_clock_sequencer
//
// Generates the four-phase trapezoidal power-clock schedule for the adiabatic
// datapath. Each phase p runs RISE -> HOLD -> FALL -> REST. One segment lasts
// STEPS cycles. Phase p lags phase 0 by p segments. For each phase the block
// emits a stepwise-charging tap index for the clkpos rail and the complementary
// index for the clkneg rail. Phase p powers pipeline stage p mod 4.
//
// Modes:
//   IDLE  - all rails at rest (pos = 0, neg = STEPS).
//   RUN   - normal four-phase sequencing.
//   DRAIN - entered when en is low at the end of segment 3. New rises are
//           suppressed and phases already charged are let down. The block
//           returns to IDLE at the end of segment 1.
//
// Handshake: none. en is a level run request. It is only sampled in IDLE and
// on the last cycle of segment 3 in RUN. It is ignored during DRAIN.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   en         in   run request
//   busy       out  high in RUN or DRAIN
//   pos_tap    out  clkpos tap per phase, phase p at [p*TW +: TW]
//   neg_tap    out  clkneg tap per phase (STEPS - pos_tap), same packing
//   seg        out  current segment index 0..3
//   seg_tick   out  high on the last cycle of every segment while busy
//   cycle_cnt  out  completed RUN cycles, wraps modulo 2^CW
//   mode_o     out  FSM state (0 = IDLE, 1 = RUN, 2 = DRAIN), for observation
// -----------------------------------------------------------------------------
module adiabatic_clock_sequencer #(
  parameter int STEPS = 4,
  parameter int CW    = 16,
  localparam int TW   = $clog2(STEPS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic            busy,
  output logic [4*TW-1:0] pos_tap,
  output logic [4*TW-1:0] neg_tap,
  output logic [1:0]      seg,
  output logic            seg_tick,
  output logic [CW-1:0]   cycle_cnt,
  output logic [1:0]      mode_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mode_t;

  localparam logic [TW-1:0] STEPS_T = TW'(STEPS);
  localparam logic [TW-1:0] LAST_T  = TW'(STEPS - 1);

  mode_t         mode_q, mode_d;
  logic [1:0]    seg_q, seg_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          seg_end;

  assign seg_end = (cnt_q == LAST_T);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= IDLE;
      seg_q  <= 2'd0;
      cnt_q  <= '0;
      cyc_q  <= '0;
    end else begin
      mode_q <= mode_d;
      seg_q  <= seg_d;
      cnt_q  <= cnt_d;
      cyc_q  <= cyc_d;
    end
  end

  // Next-state logic
  always_comb begin
    mode_d = mode_q;
    seg_d  = seg_q;
    cnt_d  = cnt_q;
    cyc_d  = cyc_q;
    case (mode_q)
      IDLE: begin
        if (en) begin
          mode_d = RUN;
          seg_d  = 2'd0;
          cnt_d  = '0;
        end
      end
      RUN: begin
        if (seg_end) begin
          cnt_d = '0;
          seg_d = seg_q + 2'd1;
          // The 3 -> 0 wrap completes a cycle even when this is the stop point.
          if (seg_q == 2'd3) begin
            cyc_d = cyc_q + CW'(1);
            if (!en) mode_d = DRAIN;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DRAIN: begin
        if (seg_end) begin
          cnt_d = '0;
          if (seg_q == 2'd1) begin
            mode_d = IDLE;
            seg_d  = 2'd0;
          end else begin
            seg_d = seg_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: begin
        mode_d = IDLE;
        seg_d  = 2'd0;
        cnt_d  = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    logic [1:0]    ps;
    logic [TW-1:0] tap;
    logic          active;
    busy      = (mode_q != IDLE);
    seg_tick  = busy && seg_end;
    seg       = seg_q;
    cycle_cnt = cyc_q;
    mode_o    = mode_q;
    pos_tap   = '0;
    neg_tap   = '0;
    for (int p = 0; p < 4; p++) begin
      ps  = seg_q - 2'(p);
      tap = '0;
      // During DRAIN only the phases that had charged before the stop boundary
      // are allowed to finish. Those are the phases with index above the
      // current drain segment. Every other phase stays at rest.
      active = (mode_q == RUN) || ((mode_q == DRAIN) && (2'(p) > seg_q));
      if (active) begin
        case (ps)
          2'd0:    tap = (mode_q == RUN) ? (cnt_q + TW'(1)) : '0;  // RISE
          2'd1:    tap = STEPS_T;                                  // HOLD
          2'd2:    tap = LAST_T - cnt_q;                           // FALL
          default: tap = '0;                                       // REST
        endcase
      end
      pos_tap[p*TW +: TW] = tap;
      neg_tap[p*TW +: TW] = STEPS_T - tap;
    end
  end

endmodule

// File: tb/tb_adiabatic_clock_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for adiabatic_clock_sequencer.
//   u0: STEPS=4, CW=16 - start, steady run, mid-period en glitch, drain, en
//       ignored in drain, restart, reset mid-rise.
//   u1: STEPS=2, CW=4  - ramp shape for the small build and cycle_cnt wrap.
// Expected output words are built from the reference phase-0 waveform. Each
// expected word is queued when its stimulus is driven and popped for the
// check made after the clock edge.
// -----------------------------------------------------------------------------
module tb_adiabatic_clock_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0 = 1'b1, en0 = 1'b0;
  logic reset1 = 1'b1, en1 = 1'b0;

  logic        busy0, tick0;
  logic [1:0]  seg0, mode0;
  logic [11:0] pos0, neg0;
  logic [15:0] cyc0;

  logic        busy1, tick1;
  logic [1:0]  seg1, mode1;
  logic [7:0]  pos1, neg1;
  logic [3:0]  cyc1;

  adiabatic_clock_sequencer #(.STEPS(4), .CW(16)) u0 (
    .clk(clk), .reset(reset0), .en(en0), .busy(busy0), .pos_tap(pos0),
    .neg_tap(neg0), .seg(seg0), .seg_tick(tick0), .cycle_cnt(cyc0),
    .mode_o(mode0)
  );

  adiabatic_clock_sequencer #(.STEPS(2), .CW(4)) u1 (
    .clk(clk), .reset(reset1), .en(en1), .busy(busy1), .pos_tap(pos1),
    .neg_tap(neg1), .seg(seg1), .seg_tick(tick1), .cycle_cnt(cyc1),
    .mode_o(mode1)
  );

  logic [63:0] obs0, obs1;
  assign obs0 = {20'b0, busy0, seg0, tick0, pos0, neg0, cyc0};
  assign obs1 = {40'b0, busy1, seg1, tick1, pos1, neg1, cyc1};

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int tab0[16];
  int tab1[8];

  function automatic logic [63:0] e0(input logic b, input logic [1:0] s,
                                     input logic t, input int p0, input int p1,
                                     input int p2, input int p3,
                                     input logic [15:0] c);
    logic [11:0] pos, neg;
    pos = {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    neg = {3'(4 - p3), 3'(4 - p2), 3'(4 - p1), 3'(4 - p0)};
    return {20'b0, b, s, t, pos, neg, c};
  endfunction

  function automatic logic [63:0] e1(input logic b, input logic [1:0] s,
                                     input logic t, input int p0, input int p1,
                                     input int p2, input int p3,
                                     input logic [3:0] c);
    logic [7:0] pos, neg;
    pos = {2'(p3), 2'(p2), 2'(p1), 2'(p0)};
    neg = {2'(2 - p3), 2'(2 - p2), 2'(2 - p1), 2'(2 - p0)};
    return {40'b0, b, s, t, pos, neg, c};
  endfunction

  // k = cycles since the start edge; phase p lags phase 0 by 4p cycles.
  function automatic logic [63:0] run0(input int k, input int cbase);
    return e0(1'b1, 2'((k / 4) % 4), (k % 4) == 3,
              tab0[k % 16], tab0[(k + 12) % 16], tab0[(k + 8) % 16],
              tab0[(k + 4) % 16], 16'(cbase + k / 16));
  endfunction

  function automatic logic [63:0] run1(input int k);
    return e1(1'b1, 2'((k / 2) % 4), (k % 2) == 1,
              tab1[k % 8], tab1[(k + 6) % 8], tab1[(k + 4) % 8],
              tab1[(k + 2) % 8], 4'((k / 8) % 16));
  endfunction

  // d = cycles since the stop boundary.
  function automatic logic [63:0] drain0(input int d, input int c);
    return e0(1'b1, 2'(d / 4), (d % 4) == 3, 0, 0,
              (d < 4) ? 3 - d : 0, (d < 4) ? 4 : 7 - d, 16'(c));
  endfunction

  task automatic check(input logic [63:0] got, input string tag);
    logic [63:0] ex;
    ex = exp_q.pop_front();
    checks++;
    assert (got === ex) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, ex);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step0(input logic rst, input logic en_v,
                       input logic [63:0] e, input string tag);
    reset0 = rst;
    en0    = en_v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(obs0, tag);
  endtask

  task automatic step1(input logic rst, input logic en_v,
                       input logic [63:0] e, input string tag);
    reset1 = rst;
    en1    = en_v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(obs1, tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tab0 = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0, 0, 0, 0};
    tab1 = '{1, 2, 2, 2, 1, 0, 0, 0};

    // Reset state, and reset priority over en.
    step0(1'b1, 1'b0, e0(0, 0, 0, 0, 0, 0, 0, 0), "reset");
    step0(1'b1, 1'b1, e0(0, 0, 0, 0, 0, 0, 0, 0), "reset_with_en");

    // Start, five periods of RUN. en dips mid-period in the 4th period.
    step0(1'b0, 1'b1, run0(0, 0), "start");
    for (int k = 1; k < 80; k++)
      step0(1'b0, !(k >= 52 && k <= 57), run0(k, 0), "run");

    // Stop at the seg3 boundary. en goes back high during the drain and
    // must be ignored until IDLE.
    for (int d = 0; d < 8; d++)
      step0(1'b0, d != 0, drain0(d, 5), "drain");
    step0(1'b0, 1'b1, e0(0, 0, 0, 0, 0, 0, 0, 5), "idle_after_drain");

    // Restart from IDLE, then reset while phase 0 is at tap 2.
    step0(1'b0, 1'b1, run0(0, 5), "restart");
    step0(1'b0, 1'b1, run0(1, 5), "restart_rise");
    step0(1'b1, 1'b1, e0(0, 0, 0, 0, 0, 0, 0, 0), "reset_mid_rise");
    step0(1'b0, 1'b0, e0(0, 0, 0, 0, 0, 0, 0, 0), "idle_after_reset");
    reset0 = 1'b1;

    // Small build: STEPS=2, CW=4. cycle_cnt wraps after 16 periods.
    step1(1'b1, 1'b0, e1(0, 0, 0, 0, 0, 0, 0, 0), "s2_reset");
    for (int k = 0; k < 136; k++)
      step1(1'b0, 1'b1, run1(k), "s2_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
